// File: rtl/tank_pkg.sv
// Shared types and helpers for the per-player tank controller.
// Latency: none, types and a pure combinational function only.
// Backpressure: not applicable.
package tank_pkg;

  // 8-way heading, clockwise from north
  typedef enum logic [2:0] {
    H_N  = 3'd0,
    H_NE = 3'd1,
    H_E  = 3'd2,
    H_SE = 3'd3,
    H_S  = 3'd4,
    H_SW = 3'd5,
    H_W  = 3'd6,
    H_NW = 3'd7
  } heading_t;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    COOLDOWN = 2'd1,
    WAIT_REL = 2'd2
  } fire_state_t;

  // Unit direction vector; each component is -1, 0 or +1
  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } dir_t;

  // Default HID usage codes (W, S, A, D, space)
  localparam logic [7:0] KEY_FWD_DEF   = 8'h1A;
  localparam logic [7:0] KEY_BACK_DEF  = 8'h16;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h04;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h07;
  localparam logic [7:0] KEY_FIRE_DEF  = 8'h2C;

  // Screen coordinates: y grows downward, so north is dy = -1
  function automatic dir_t dir_vec(input heading_t h);
    dir_t v;
    case (h)
      H_N:     v = '{dx:  2'sd0, dy: -2'sd1};
      H_NE:    v = '{dx:  2'sd1, dy: -2'sd1};
      H_E:     v = '{dx:  2'sd1, dy:  2'sd0};
      H_SE:    v = '{dx:  2'sd1, dy:  2'sd1};
      H_S:     v = '{dx:  2'sd0, dy:  2'sd1};
      H_SW:    v = '{dx: -2'sd1, dy:  2'sd1};
      H_W:     v = '{dx: -2'sd1, dy:  2'sd0};
      default: v = '{dx: -2'sd1, dy: -2'sd1};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tank_key_match.sv
// Flags whether a given HID usage code is present in any of the four key slots.
// Latency: combinational.
// Backpressure: none, pure decode.
module tank_key_match (
  input  logic [31:0] keycode,
  input  logic [7:0]  key,
  output logic        hit
);

  // key is nonzero, so empty (8'h00) slots can never produce a hit
  assign hit = (keycode[7:0]   == key) |
               (keycode[15:8]  == key) |
               (keycode[23:16] == key) |
               (keycode[31:24] == key);

endmodule

// File: rtl/tank_motion.sv
// Per-player tank controller: key decode, 8-way heading, clamped motion, rate-limited fire.
// Latency: one frame, keycode sampled at edge k shows on every output after edge k.
// Backpressure: none, runs once per frame and never stalls.
module tank_motion
  import tank_pkg::*;
#(
  parameter int         X_CENTER      = 320,
  parameter int         Y_CENTER      = 240,
  parameter int         X_MIN         = 0,
  parameter int         X_MAX         = 639,
  parameter int         Y_MIN         = 0,
  parameter int         Y_MAX         = 479,
  parameter int         SIZE          = 10,
  parameter int         STEP          = 1,
  parameter int         ROT_DELAY     = 8,
  parameter int         FIRE_COOLDOWN = 30,
  parameter heading_t   INIT_HEADING  = H_N,
  parameter logic [7:0] KEY_FWD       = KEY_FWD_DEF,
  parameter logic [7:0] KEY_BACK      = KEY_BACK_DEF,
  parameter logic [7:0] KEY_LEFT      = KEY_LEFT_DEF,
  parameter logic [7:0] KEY_RIGHT     = KEY_RIGHT_DEF,
  parameter logic [7:0] KEY_FIRE      = KEY_FIRE_DEF
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [31:0] keycode,
  input  logic        enable,
  output logic [9:0]  TankX,
  output logic [9:0]  TankY,
  output logic [9:0]  TankS,
  output logic [2:0]  heading,
  output logic        fire_pulse,
  output logic        moving
);

  localparam int RW = $clog2(ROT_DELAY + 1);
  localparam int CW = $clog2(FIRE_COOLDOWN + 1);

  localparam logic signed [10:0] X_LO   = 11'(X_MIN + SIZE);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN + SIZE);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  logic fwd_hit, back_hit, left_hit, right_hit, fire_hit;

  tank_key_match u_key_fwd   (.keycode(keycode), .key(KEY_FWD),   .hit(fwd_hit));
  tank_key_match u_key_back  (.keycode(keycode), .key(KEY_BACK),  .hit(back_hit));
  tank_key_match u_key_left  (.keycode(keycode), .key(KEY_LEFT),  .hit(left_hit));
  tank_key_match u_key_right (.keycode(keycode), .key(KEY_RIGHT), .hit(right_hit));
  tank_key_match u_key_fire  (.keycode(keycode), .key(KEY_FIRE),  .hit(fire_hit));

  // Registered state
  logic [9:0]  pos_x, pos_y;
  heading_t    heading_q;
  logic [RW-1:0] rot_cnt;
  fire_state_t fire_q;
  logic [CW-1:0] cd_cnt;
  logic        pulse_q, moving_q;

  // Next-state values
  logic [9:0]  pos_x_nxt, pos_y_nxt;
  heading_t    heading_nxt;
  logic [RW-1:0] rot_cnt_nxt;
  fire_state_t fire_nxt;
  logic [CW-1:0] cd_nxt;
  logic        pulse_nxt, moving_nxt;

  logic              drive, back_only;
  dir_t              vec;
  logic signed [10:0] dx_ext, dy_ext, dlt_x, dlt_y, cand_x, cand_y;

  function automatic logic [9:0] clamp(input logic signed [10:0] c,
                                       input logic signed [10:0] lo,
                                       input logic signed [10:0] hi);
    if (c < lo) return lo[9:0];
    if (c > hi) return hi[9:0];
    return c[9:0];
  endfunction

  // Rotation and drive: motion uses the heading registered before this frame's rotation
  always_comb begin
    heading_nxt = heading_q;
    rot_cnt_nxt = rot_cnt;
    pos_x_nxt   = pos_x;
    pos_y_nxt   = pos_y;
    moving_nxt  = 1'b0;

    drive     = fwd_hit ^ back_hit;
    back_only = back_hit & ~fwd_hit;
    vec       = dir_vec(heading_q);
    dx_ext    = {{9{vec.dx[1]}}, vec.dx};
    dy_ext    = {{9{vec.dy[1]}}, vec.dy};
    dlt_x     = '0;
    dlt_y     = '0;
    if (drive) begin
      dlt_x = back_only ? -(dx_ext * STEP_S) : (dx_ext * STEP_S);
      dlt_y = back_only ? -(dy_ext * STEP_S) : (dy_ext * STEP_S);
    end
    cand_x = $signed({1'b0, pos_x}) + dlt_x;
    cand_y = $signed({1'b0, pos_y}) + dlt_y;

    if (enable) begin
      if (left_hit ^ right_hit) begin
        if (rot_cnt == '0) begin
          heading_nxt = left_hit ? heading_t'(heading_q - 3'd1)
                                 : heading_t'(heading_q + 3'd1);
          rot_cnt_nxt = RW'(ROT_DELAY - 1);
        end else begin
          rot_cnt_nxt = rot_cnt - RW'(1);
        end
      end else begin
        // Released (or both held): next press rotates immediately
        rot_cnt_nxt = '0;
      end

      if (drive) begin
        // Axes clamp independently so diagonal moves slide along walls
        pos_x_nxt  = clamp(cand_x, X_LO, X_HI);
        pos_y_nxt  = clamp(cand_y, Y_LO, Y_HI);
        moving_nxt = 1'b1;
      end
    end
  end

  // Fire FSM: one pulse per press, cooldown and release wait keep running while disabled
  always_comb begin
    fire_nxt  = fire_q;
    cd_nxt    = cd_cnt;
    pulse_nxt = 1'b0;
    case (fire_q)
      READY: begin
        if (fire_hit && enable) begin
          fire_nxt  = COOLDOWN;
          cd_nxt    = CW'(FIRE_COOLDOWN - 1);
          pulse_nxt = 1'b1;
        end
      end
      COOLDOWN: begin
        if (cd_cnt == '0) begin
          fire_nxt = fire_hit ? WAIT_REL : READY;
        end else begin
          cd_nxt = cd_cnt - CW'(1);
        end
      end
      WAIT_REL: begin
        if (!fire_hit) fire_nxt = READY;
      end
      default: fire_nxt = READY;
    endcase
  end

  // State register with synchronous active-low reset overriding keys and enable
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      pos_x     <= 10'(X_CENTER);
      pos_y     <= 10'(Y_CENTER);
      heading_q <= INIT_HEADING;
      rot_cnt   <= '0;
      fire_q    <= READY;
      cd_cnt    <= '0;
      pulse_q   <= 1'b0;
      moving_q  <= 1'b0;
    end else begin
      pos_x     <= pos_x_nxt;
      pos_y     <= pos_y_nxt;
      heading_q <= heading_nxt;
      rot_cnt   <= rot_cnt_nxt;
      fire_q    <= fire_nxt;
      cd_cnt    <= cd_nxt;
      pulse_q   <= pulse_nxt;
      moving_q  <= moving_nxt;
    end
  end

  assign TankX      = pos_x;
  assign TankY      = pos_y;
  assign TankS      = 10'(SIZE);
  assign heading    = heading_q;
  assign fire_pulse = pulse_q;
  assign moving     = moving_q;

endmodule

// File: tb/tb_tank_motion.sv
// Directed self-checking bench for tank_motion with default parameters.
// Latency: checks outputs 1 time unit after each frame edge.
// Backpressure: not applicable.
module tb_tank_motion;

  logic        frame_clk = 1'b0;
  logic        Reset_n   = 1'b0;
  logic [31:0] keycode   = 32'h0;
  logic        enable    = 1'b0;
  logic [9:0]  TankX, TankY, TankS;
  logic [2:0]  heading;
  logic        fire_pulse, moving;

  int n_checks = 0;
  int n_fail   = 0;

  tank_motion dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode   (keycode),
    .enable    (enable),
    .TankX     (TankX),
    .TankY     (TankY),
    .TankS     (TankS),
    .heading   (heading),
    .fire_pulse(fire_pulse),
    .moving    (moving)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [31:0] key;
    int          x;
    int          y;
    int          h;
    logic        p;
    logic        m;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, let one frame edge pass, sample just after it
  task automatic frame(input logic rst_n, input logic en, input logic [31:0] key);
    Reset_n = rst_n;
    enable  = en;
    keycode = key;
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    int pulses;
    string tag;

    //            rst   en    keycode        x    y    h  p     m
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 320, 240, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_001A, 320, 239, 0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_1A00, 320, 238, 0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 32'h001A_0000, 320, 237, 0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 32'h1A00_0000, 320, 236, 0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 32'h0000_001A, 320, 235, 0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 32'h1A16_0407, 320, 235, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_071A, 320, 235, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'h0000_0016, 320, 236, 0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 32'h0000_071A, 320, 235, 1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'h0000_001A, 321, 234, 1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 32'h0000_0004, 321, 234, 0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 32'h0000_0004, 321, 234, 0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 32'h0000_0704, 321, 234, 0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 32'h0000_0004, 321, 234, 7, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 32'h0000_001A, 320, 233, 7, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 32'h0000_001A, 320, 240, 0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 32'h0000_002C, 320, 240, 0, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 32'h0000_0000, 320, 240, 0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 32'h0000_0000, 320, 240, 0, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 32'h2C00_0000, 320, 240, 0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 32'h2C00_0000, 320, 240, 0, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 32'h0000_2C00, 320, 240, 0, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 1'b1, 32'h0000_2C00, 320, 240, 0, 1'b1, 1'b0};
    tbl[24] = '{1'b0, 1'b1, 32'h0000_0000, 320, 240, 0, 1'b0, 1'b0};
    tbl[25] = '{1'b1, 1'b1, 32'h2C07_1A00, 320, 239, 1, 1'b1, 1'b1};
    tbl[26] = '{1'b0, 1'b1, 32'h0000_0000, 320, 240, 0, 1'b0, 1'b0};

    // Table-driven single-frame vectors
    for (int i = 0; i < NV; i++) begin
      frame(tbl[i].rst_n, tbl[i].en, tbl[i].key);
      tag = $sformatf("vec%0d", i);
      chk({tag, ".x"},       int'(TankX),      tbl[i].x);
      chk({tag, ".y"},       int'(TankY),      tbl[i].y);
      chk({tag, ".heading"}, int'(heading),    tbl[i].h);
      chk({tag, ".pulse"},   int'(fire_pulse), int'(tbl[i].p));
      chk({tag, ".moving"},  int'(moving),     int'(tbl[i].m));
    end
    chk("size", int'(TankS), 10);

    // Held right key steps heading at frames 1, 9, 17
    frame(1'b0, 1'b1, 32'h0);
    for (int f = 1; f <= 17; f++) begin
      frame(1'b1, 1'b1, 32'h0007_0000);
      chk($sformatf("rot_hold.f%0d", f), int'(heading), 1 + (f - 1) / 8);
    end
    frame(1'b1, 1'b1, 32'h0);
    chk("rot_release", int'(heading), 3);
    frame(1'b1, 1'b1, 32'h0000_0007);
    chk("rot_repress", int'(heading), 4);

    // Face east and drive into the right wall
    frame(1'b0, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_0007);
    frame(1'b1, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_0007);
    frame(1'b1, 1'b1, 32'h0);
    chk("east.heading", int'(heading), 2);
    for (int f = 1; f <= 400; f++) begin
      frame(1'b1, 1'b1, 32'h0000_001A);
      if (f == 308 || f == 309 || f == 310 || f == 400 || f == 1) begin
        chk($sformatf("east.x.f%0d", f), int'(TankX), (320 + f > 629) ? 629 : 320 + f);
        chk($sformatf("east.y.f%0d", f), int'(TankY), 240);
      end
    end
    // Turn NE and slide up the wall into the top-right corner
    frame(1'b1, 1'b1, 32'h0000_0004);
    frame(1'b1, 1'b1, 32'h0);
    chk("ne.heading", int'(heading), 1);
    for (int f = 1; f <= 250; f++) begin
      frame(1'b1, 1'b1, 32'h0000_1A00);
      if (f <= 3 || f == 229 || f == 230 || f == 231 || f == 250) begin
        chk($sformatf("ne.x.f%0d", f), int'(TankX), 629);
        chk($sformatf("ne.y.f%0d", f), int'(TankY), (240 - f < 10) ? 10 : 240 - f);
      end
    end
    chk("ne.moving", int'(moving), 1);
    // Reverse from the corner: SW vector heads back into open field
    frame(1'b1, 1'b1, 32'h0000_0016);
    chk("back.x", int'(TankX), 628);
    chk("back.y", int'(TankY), 11);

    // Held fire gives exactly one pulse, no auto-repeat
    frame(1'b0, 1'b1, 32'h0);
    pulses = 0;
    for (int f = 1; f <= 100; f++) begin
      frame(1'b1, 1'b1, 32'h002C_0000);
      if (f == 1) chk("fire.first", int'(fire_pulse), 1);
      pulses += int'(fire_pulse);
    end
    chk("fire.held_count", pulses, 1);
    frame(1'b1, 1'b1, 32'h0);
    chk("fire.release", int'(fire_pulse), 0);
    frame(1'b1, 1'b1, 32'h002C_0000);
    chk("fire.repress", int'(fire_pulse), 1);

    // Release for the full cooldown, repress at FIRE_COOLDOWN+1 frames
    pulses = 0;
    for (int f = 1; f <= 30; f++) begin
      frame(1'b1, 1'b1, 32'h0);
      pulses += int'(fire_pulse);
    end
    chk("cd.quiet", pulses, 0);
    frame(1'b1, 1'b1, 32'h0000_002C);
    chk("cd.spacing31", int'(fire_pulse), 1);

    // Repress one frame too early lands in the release wait
    for (int f = 1; f <= 29; f++) frame(1'b1, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_002C);
    chk("cd.early30", int'(fire_pulse), 0);
    frame(1'b1, 1'b1, 32'h0000_002C);
    chk("cd.wait_rel", int'(fire_pulse), 0);
    frame(1'b1, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_002C);
    chk("cd.after_wait", int'(fire_pulse), 1);

    // Cooldown keeps running while disabled
    for (int f = 1; f <= 30; f++) frame(1'b1, 1'b0, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_002C);
    chk("cd.disabled_adv", int'(fire_pulse), 1);

    // Reset mid-cooldown with the tank moved away from centre
    frame(1'b0, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_0007);
    frame(1'b1, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_0007);
    frame(1'b1, 1'b1, 32'h0);
    for (int f = 1; f <= 180; f++) frame(1'b1, 1'b1, 32'h0000_001A);
    frame(1'b1, 1'b1, 32'h0000_0004);
    frame(1'b1, 1'b1, 32'h0000_0004);
    frame(1'b1, 1'b1, 32'h0);
    frame(1'b1, 1'b1, 32'h0000_0004);
    frame(1'b1, 1'b1, 32'h0);
    for (int f = 1; f <= 140; f++) frame(1'b1, 1'b1, 32'h0000_001A);
    chk("pre_rst.x", int'(TankX), 500);
    chk("pre_rst.y", int'(TankY), 100);
    frame(1'b1, 1'b1, 32'h0000_002C);
    chk("pre_rst.pulse", int'(fire_pulse), 1);
    frame(1'b1, 1'b1, 32'h0);
    frame(1'b0, 1'b1, 32'h0000_002C);
    chk("rst.x", int'(TankX), 320);
    chk("rst.y", int'(TankY), 240);
    chk("rst.heading", int'(heading), 0);
    chk("rst.pulse", int'(fire_pulse), 0);
    frame(1'b1, 1'b1, 32'h0000_002C);
    chk("rst.fire_ready", int'(fire_pulse), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tank_motion.md
# tank_motion

Parametrised per-player tank controller for the tank-game frame pipeline. It decodes the 4-slot USB keycode word into rotate, drive and fire commands, and keeps an 8-way heading. It moves the tank along that heading with per-axis wall clamping and no one-frame motion lag, and issues rate-limited single-frame fire pulses to the projectile logic. One instance per player; outputs feed the sprite/colour mapper and the shell spawner.

## Interface
- X_CENTER, 320: reset X position
- Y_CENTER, 240: reset Y position
- X_MIN / X_MAX, 0 / 639: horizontal playfield bounds, inclusive
- Y_MIN / Y_MAX, 0 / 479: vertical playfield bounds, inclusive
- SIZE, 10: tank half-extent in pixels
- STEP, 1: pixels moved per axis per frame, range 1..7
- ROT_DELAY, 8: frames between heading steps while a rotate key is held, ≥1
- FIRE_COOLDOWN, 30: frames of lockout after a shot, ≥1
- INIT_HEADING, 0: heading after reset
- KEY_FWD / KEY_BACK / KEY_LEFT / KEY_RIGHT / KEY_FIRE, 8'h1A / 8'h16 / 8'h04 / 8'h07 / 8'h2C: HID usage codes; must be nonzero and distinct
- frame_clk  in  1  frame-rate clock, one edge per video frame
- Reset_n  in  1  one clock; reset is synchronous and active-low
- keycode  in  32  four HID key slots; 8'h00 means an empty slot
- enable  in  1  game-running qualifier
- TankX, TankY  out  10  tank centre position
- TankS  out  10  constant SIZE
- heading  out  3  0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW (clockwise)
- fire_pulse  out  1  one-frame shot request
- moving  out  1  drive command was applied this frame

## Operation
- Key decode: a key is "held" when any of the 4 keycode bytes equals its code. Key order within the word is irrelevant.
- Rotation (enable=1):
  - LEFT xor RIGHT held, rot_cnt==0: heading steps −1 (LEFT) or +1 (RIGHT) mod 8, and rot_cnt loads ROT_DELAY−1.
  - Held with rot_cnt≠0: rot_cnt decrements.
  - Neither key or both keys held: heading is unchanged and rot_cnt is 0. The next press therefore rotates immediately.
- Drive (enable=1):
  - FWD xor BACK held: apply vector v(heading) times STEP (forward) or times −STEP (back).
  - Direction table: N(0,−1) NE(+1,−1) E(+1,0) SE(+1,+1) S(0,+1) SW(−1,+1) W(−1,0) NW(−1,−1).
  - The vector uses the registered heading from before this frame's rotation.
  - Neither or both held: no motion, and moving=0.
- Position arithmetic: candidate = pos + delta, computed as 11-bit signed.
  - Clamp each axis independently: candidate < MIN+SIZE gives MIN+SIZE; candidate > MAX−SIZE gives MAX−SIZE.
  - Independent clamping lets a diagonal move slide along a wall.
  - The new position is registered on the same edge the key is sampled. There is no separate motion register and no bounce.
- Fire FSM:
  - READY → COOLDOWN: FIRE held and enable=1. Assert fire_pulse for one frame and load cd_cnt=FIRE_COOLDOWN−1.
  - COOLDOWN: cd_cnt decrements. At cd_cnt==0, go to WAIT_REL if FIRE is held, else READY.
  - WAIT_REL → READY: on the first frame FIRE is not held.
  - Holding FIRE therefore never auto-repeats.
- enable=0: position, heading and rot_cnt hold. moving=0. No new shot is issued, but COOLDOWN/WAIT_REL keep advancing.
- Reset (Reset_n=0 at an edge):
  - TankX=X_CENTER, TankY=Y_CENTER, heading=INIT_HEADING.
  - rot_cnt=0, FSM=READY, cd_cnt=0, fire_pulse=0, moving=0.
  - Reset applied mid-cooldown or mid-rotation discards all progress.

## Timing
- All outputs are registered. Keycode sampled at edge k is reflected in outputs after edge k, i.e. one frame of latency.
- A held rotate key steps heading at edges k, k+ROT_DELAY, k+2·ROT_DELAY, …
- fire_pulse is high for exactly one frame. For a release-and-repress sequence, consecutive pulses are ≥FIRE_COOLDOWN+1 frames apart.
- Simultaneous rotate, drive and fire in one frame are all legal:
  - Drive uses the old heading.
  - fire_pulse coincides with the heading update. The spawner samples the heading output one frame later.
- Reset overrides enable and all keys.

## Structure
- Shared package tank_pkg holds:
  - heading_t: 3-bit enum H_N…H_NW.
  - fire_state_t: READY, COOLDOWN, WAIT_REL.
  - Function dir_vec(heading_t) returning signed dx/dy in −1..1.
  - Default HID key constants.
- Sub-module tank_key_match(keycode, key → hit) is instantiated five times. Everything else is one always_ff plus combinational next-state logic.

## Test plan
- Reset, then hold 8'h1A with heading=0 for 5 frames → TankY=235, TankX=320, moving=1 from the first frame after the press.
- From reset, hold 8'h07 with ROT_DELAY=8 for 17 frames → heading 1, 2, 3 at frames 1, 9, 17. Release and press again → heading 4 on the next frame.
- Heading=2 (E), hold forward 400 frames → TankX saturates at 629 after 309 frames, TankY stays 240. Then set heading=1 (NE) and drive → X stays 629 while Y decreases by 1 per frame.
- Hold 8'h2C continuously for 100 frames → exactly one fire_pulse. Release for 1 frame after the 30-frame cooldown, press again → second pulse.
- Keycode 32'h1A16_0407 (all four keys in different slots) → no motion, no rotation, moving=0.
- Pull Reset_n low during COOLDOWN with the tank at (500,100) → next frame shows (320,240), heading=0, FIRE_state=READY. FIRE pressed on the following frame → immediate fire_pulse.
